// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, lane widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

   // RISC-V load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte-within-word index width for a 32-bit word
   localparam int BYTE_LANE_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_STORE  = 3'd3,
      ST_RESP   = 3'd4
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: load extraction/extension, sub-word store merge, fault detect.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from whatever request fields the parent selects.
//
// Ports:
//   we        1 = store, 0 = load
//   funct3    access size / sign
//   addr_lo   byte offset within the word
//   mem_word  current memory word at the word-aligned address
//   st_data   right-aligned store data
//   ld_data   extended load value
//   st_word   memory word with the store data merged into the addressed lane
//   fault     misaligned access or funct3 not legal for this direction
module lsu_align
   import lsu_pkg::*;
(
   input  logic                   we,
   input  logic [2:0]             funct3,
   input  logic [BYTE_LANE_W-1:0] addr_lo,
   input  logic [31:0]            mem_word,
   input  logic [31:0]            st_data,
   output logic [31:0]            ld_data,
   output logic [31:0]            st_word,
   output logic                   fault
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        legal;
   logic        misaligned;

   always_comb begin
      ld_byte = mem_word[{addr_lo, 3'b000} +: 8];
      ld_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

      case (funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0, ld_half};
         F3_W:    ld_data = mem_word;
         default: ld_data = 32'h0;
      endcase

      // Untouched lanes keep the value read from memory
      st_word = mem_word;
      case (funct3)
         F3_B: st_word[{addr_lo, 3'b000} +: 8] = st_data[7:0];
         F3_H: begin
            if (addr_lo[1]) st_word[31:16] = st_data[15:0];
            else            st_word[15:0]  = st_data[15:0];
         end
         F3_W:    st_word = st_data;
         default: st_word = mem_word;
      endcase

      if (we) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);

      // funct3[1:0] is the size for every legal encoding: 01 = half, 10 = word
      misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

      fault = !legal || misaligned;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time to a word-wide memory (comb read, sync write), RMW for SB/SH.
// Latency: accept->resp_valid 1 cycle on fault, 2 for loads and SW, 3 for SB/SH.
// Backpressure: req_ready is high only in IDLE; requests seen while busy are ignored, not queued.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_we, req_funct3, req_addr, req_wdata latched on accept
//   resp_valid               one-cycle response strobe; resp_rdata/resp_fault hold until the next response
//   mem_wr_en, mem_addr,     memory write strobe, word-aligned address and full write word
//   mem_wr_data
//   mem_rd_data              combinational read data for mem_addr
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_fault,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   lsu_state_t state_q, state_d;

   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic                  idle;
   logic                  al_we;
   logic [2:0]            al_funct3;
   logic [BYTE_LANE_W-1:0] al_addr_lo;
   logic [DATA_WIDTH-1:0] al_st_data;
   logic [DATA_WIDTH-1:0] al_ld_data;
   logic [DATA_WIDTH-1:0] al_st_word;
   logic                  al_fault;

   assign idle = (state_q == ST_IDLE);

   // In IDLE the aligner sees the incoming request so the fault decision is ready at the
   // accept edge; afterwards it works from the latched request. Only registered values
   // reach the mem_* outputs.
   assign al_we      = idle ? req_we                       : r_we;
   assign al_funct3  = idle ? req_funct3                   : r_funct3;
   assign al_addr_lo = idle ? req_addr[BYTE_LANE_W-1:0]    : r_addr[BYTE_LANE_W-1:0];
   assign al_st_data = idle ? req_wdata                    : r_wdata;

   lsu_align u_align (
      .we       (al_we),
      .funct3   (al_funct3),
      .addr_lo  (al_addr_lo),
      .mem_word (mem_rd_data),
      .st_data  (al_st_data),
      .ld_data  (al_ld_data),
      .st_word  (al_st_word),
      .fault    (al_fault)
   );

   assign mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_wr_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (al_fault)                  state_d = ST_RESP;
               else if (!req_we)              state_d = ST_LOAD;
               else if (req_funct3 == F3_W)   state_d = ST_STORE;
               else                           state_d = ST_RMW_RD;
            end
         end
         ST_LOAD:   state_d = ST_RESP;
         ST_RMW_RD: state_d = ST_STORE;
         ST_STORE: begin
            mem_wr_en = 1'b1;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         resp_rdata  <= '0;
         resp_fault  <= 1'b0;
         mem_wr_data <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  if (al_fault) begin
                     resp_rdata <= '0;
                     resp_fault <= 1'b1;
                  end else if (req_we && (req_funct3 == F3_W)) begin
                     mem_wr_data <= req_wdata;
                  end
               end
            end
            ST_LOAD: begin
               resp_rdata <= al_ld_data;
               resp_fault <= 1'b0;
            end
            ST_RMW_RD: mem_wr_data <= al_st_word;
            ST_STORE: begin
               resp_rdata <= '0;
               resp_fault <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic against a byte-array reference.
// Latency: expected accept->response latency is derived per request from access type.
// Backpressure: requests are issued only when req_ready is seen high; one scenario holds req_valid.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_fault  (resp_fault),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   // Data memory: 64 words, modulo-indexed, combinational read, synchronous write
   logic [31:0] dmem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_val = 32'h0;

   assign mem_rd_data = dmem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_wr_en) dmem[mem_addr[7:2]] <= mem_wr_data;
      if (pl_en)     dmem[pl_idx]        <= pl_val;
   end

   // Reference memory as plain bytes, little-endian
   logic [7:0] rb [0:255];

   function automatic logic [31:0] refw(input int i);
      return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; write lands at the following posedge
   task automatic preload(input int idx, input logic [31:0] v);
      pl_en  = 1'b1;
      pl_idx = 6'(idx);
      pl_val = v;
      for (int k = 0; k < 4; k++) rb[4*idx+k] = v[8*k +: 8];
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Reference behaviour of one request: response, fault, latency, write cycles; updates rb on stores
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] d, output logic f,
                        output int lat, output int wrs);
      int   a;
      int   nbytes;
      logic legal;
      logic mis;
      a     = int'(addr[7:0]);
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis   = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
      d = 32'h0; f = 1'b0; lat = 0; wrs = 0;
      if (!legal || mis) begin
         f = 1'b1; lat = 1;
      end else if (!we) begin
         lat = 2;
         case (f3)
            3'd0: d = {{24{rb[a][7]}}, rb[a]};
            3'd4: d = {24'h0, rb[a]};
            3'd1: d = {{16{rb[a+1][7]}}, rb[a+1], rb[a]};
            3'd5: d = {16'h0, rb[a+1], rb[a]};
            default: d = {rb[a+3], rb[a+2], rb[a+1], rb[a]};
         endcase
      end else begin
         nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
         for (int k = 0; k < nbytes; k++) rb[a+k] = wd[8*k +: 8];
         lat = (f3 == 3'd2) ? 2 : 3;
         wrs = 1;
      end
   endtask

   // Issue one request (called at a negedge with the unit idle) and check the whole transaction
   task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] ed;
      logic        ef;
      int          el, ew, lat, wcnt;
      model(we, f3, addr, wd, ed, ef, el, ew);
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; wcnt = 0;
      if (!ef) chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      while (!resp_valid && lat < 8) begin
         if (mem_wr_en) wcnt++;
         @(negedge clk);
         lat++;
      end
      chk("resp_seen",  32'(resp_valid), 32'd1);
      chk("latency",    32'(lat),        32'(el));
      chk("resp_rdata", resp_rdata,      ed);
      chk("resp_fault", 32'(resp_fault), 32'(ef));
      chk("wr_cycles",  32'(wcnt),       32'(ew));
      @(negedge clk);
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("mem_word", dmem[addr[7:2]], refw(int'(addr[7:2])));
   endtask

   initial begin : main
      logic [31:0] q [$];
      logic [31:0] hold_addr [3];
      logic [31:0] exp_d;
      int acc, rsp;

      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) preload(i, 32'h0);
      preload(4, 32'h8899AABB);

      // Reset state
      chk("rst_ready",      32'(req_ready),  32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata",      resp_rdata,      32'h0);
      chk("rst_fault",      32'(resp_fault), 32'd0);
      chk("rst_wr_en",      32'(mem_wr_en),  32'd0);
      chk("rst_mem_addr",   mem_addr,        32'h0);
      chk("rst_wr_data",    mem_wr_data,     32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Loads from 0x8899AABB
      op(1'b0, 3'b000, 32'h11, 32'h0);
      chk("lb_value", resp_rdata, 32'hFFFFFFAA);
      op(1'b0, 3'b100, 32'h11, 32'h0);
      chk("lbu_value", resp_rdata, 32'h000000AA);
      op(1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh_value", resp_rdata, 32'hFFFF8899);
      op(1'b0, 3'b101, 32'h12, 32'h0);
      chk("lhu_value", resp_rdata, 32'h00008899);
      op(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_value", resp_rdata, 32'h8899AABB);

      // Sub-word stores via read-modify-write
      op(1'b1, 3'b000, 32'h13, 32'h123456CC);
      chk("sb_word", dmem[4], 32'hCC99AABB);
      op(1'b1, 3'b001, 32'h10, 32'h0000BEEF);
      chk("sh_word", dmem[4], 32'hCC99BEEF);
      op(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
      chk("sw_word", dmem[5], 32'hDEADBEEF);

      // Faults: misaligned, illegal funct3
      op(1'b0, 3'b010, 32'h12, 32'h0);
      op(1'b1, 3'b001, 32'h11, 32'hFFFF);
      op(1'b0, 3'b011, 32'h10, 32'h0);
      op(1'b1, 3'b100, 32'h10, 32'h55);
      chk("fault_flag", 32'(resp_fault), 32'd1);
      chk("fault_word_untouched", dmem[4], 32'hCC99BEEF);

      // Reset while the SB read phase is in progress
      preload(4, 32'h8899AABB);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_wr_en", 32'(mem_wr_en),  32'd0);
      chk("midrst_ready", 32'(req_ready),  32'd1);
      chk("midrst_resp",  32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("postrst_wr_en", 32'(mem_wr_en),  32'd0);
         chk("postrst_resp",  32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      chk("postrst_word", dmem[4], 32'h8899AABB);
      chk("postrst_ready", 32'(req_ready), 32'd1);

      // req_valid held high across three word loads
      preload(5, 32'h01234567);
      preload(6, 32'hFEDCBA98);
      hold_addr[0] = 32'h10; hold_addr[1] = 32'h14; hold_addr[2] = 32'h18;
      acc = 0; rsp = 0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = hold_addr[0];
      for (int cyc = 0; cyc < 40 && rsp < 3; cyc++) begin
         if (acc > rsp) chk("hold_busy_not_ready", 32'(req_ready), 32'd0);
         if (resp_valid) begin
            exp_d = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
            chk("hold_rdata_order", resp_rdata, exp_d);
            rsp++;
         end
         if (req_valid && req_ready) begin
            q.push_back(refw(int'(hold_addr[acc][7:2])));
            acc++;
         end
         @(negedge clk);
         if (acc >= 3) req_valid = 1'b0;
         else          req_addr  = hold_addr[acc];
      end
      chk("hold_accepts",   32'(acc), 32'd3);
      chk("hold_responses", 32'(rsp), 32'd3);
      for (int i = 0; i < 4; i++) begin
         chk("hold_no_extra_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end

      // Random traffic against the reference
      for (int i = 0; i < 64; i++) preload(i, $urandom());
      for (int n = 0; n < 200; n++) begin
         op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
